// File: rtl/multicycle_cpu.sv
// multicycle_cpu: RV32I-subset core that sequences each instruction through
// BOOT/FETCH/EXEC/MEM/WB, with req/ack handshakes to instruction and data memory.
// Decoder, register file, ALU and branch compare are implemented inline.
// Optional build macro CPU_PERF_COUNTERS_EN adds cycle/retire counters;
// without it cycleCount and retireCount are tied to zero.
module multicycle_cpu #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [31:0]              insnAddr,
   output logic                     insnReq,
   input  logic                     insnAck,
   input  logic [31:0]              insn,
   output logic [31:0]              dataAddr,
   output logic [31:0]              dataOut,
   output logic                     dataWrEnable,
   output logic                     dataReq,
   input  logic                     dataAck,
   input  logic [31:0]              dataIn,
   output logic                     insnRetired,
   output logic [COUNTER_WIDTH-1:0] cycleCount,
   output logic [COUNTER_WIDTH-1:0] retireCount
);

   localparam logic [2:0] S_BOOT  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, ir_q, alu_q, addr_q, sdata_q, npc_q, ldata_q;
   logic [31:0] rf_q [31:0];

   // Instruction fields and decoded control, all taken from the latched IR
   logic [6:0]  opcode_s;
   logic [4:0]  rd_s, rs1_s, rs2_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic        is_op_imm_s, is_op_s, is_load_s, is_store_s, is_branch_s, is_lui_s;
   logic        reg_wr_en_s, alu_const_s, alu_sub_s, br_taken_s;
   logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s;
   logic [31:0] rs1_val_s, rs2_val_s, op_a_s, op_b_s, op_b_eff_s, alu_s, wb_data_s;
   logic [2:0]  alu_fn_s;
   logic [4:0]  shamt_s;

   assign opcode_s    = ir_q[6:0];
   assign rd_s        = ir_q[11:7];
   assign funct3_s    = ir_q[14:12];
   assign rs1_s       = ir_q[19:15];
   assign rs2_s       = ir_q[24:20];
   assign funct7_s    = ir_q[31:25];
   assign is_op_imm_s = (opcode_s == 7'b0010011);
   assign is_op_s     = (opcode_s == 7'b0110011);
   assign is_load_s   = (opcode_s == 7'b0000011);
   assign is_store_s  = (opcode_s == 7'b0100011);
   assign is_branch_s = (opcode_s == 7'b1100011);
   assign is_lui_s    = (opcode_s == 7'b0110111);
   assign reg_wr_en_s = is_op_imm_s | is_op_s | is_load_s | is_lui_s;
   assign alu_const_s = is_op_imm_s | is_lui_s;
   // Subtract only for register-register add with the SUB funct7 encoding
   assign alu_sub_s   = is_op_s & (funct3_s == 3'b000) & (funct7_s == 7'b0100000);

   assign imm_i_s = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u_s = {ir_q[31:12], 12'h000};

   // Register file reads; x0 always reads as zero
   assign rs1_val_s = (rs1_s == 5'd0) ? 32'h0 : rf_q[rs1_s];
   assign rs2_val_s = (rs2_s == 5'd0) ? 32'h0 : rf_q[rs2_s];

   assign op_a_s     = is_lui_s ? 32'h0 : rs1_val_s;
   assign op_b_s     = alu_const_s ? (is_lui_s ? imm_u_s : imm_i_s) : rs2_val_s;
   assign op_b_eff_s = alu_sub_s ? (~op_b_s + 32'd1) : op_b_s;
   assign alu_fn_s   = is_lui_s ? 3'b000 : funct3_s;
   assign shamt_s    = op_b_s[4:0];

   // ALU result for the current IR
   always_comb begin
      alu_s = 32'h0;
      case (alu_fn_s)
         3'b000:  alu_s = op_a_s + op_b_eff_s;
         3'b001:  alu_s = op_a_s << shamt_s;
         3'b010:  alu_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
         3'b011:  alu_s = {31'd0, (op_a_s < op_b_s)};
         3'b100:  alu_s = op_a_s ^ op_b_s;
         3'b101:  alu_s = ir_q[30] ? 32'($signed(op_a_s) >>> shamt_s) : (op_a_s >> shamt_s);
         3'b110:  alu_s = op_a_s | op_b_s;
         3'b111:  alu_s = op_a_s & op_b_s;
         default: alu_s = 32'h0;
      endcase
   end

   // Branch condition evaluation on rs1/rs2
   always_comb begin
      br_taken_s = 1'b0;
      case (funct3_s)
         3'b000:  br_taken_s = (rs1_val_s == rs2_val_s);
         3'b001:  br_taken_s = (rs1_val_s != rs2_val_s);
         3'b100:  br_taken_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
         3'b101:  br_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
         3'b110:  br_taken_s = (rs1_val_s <  rs2_val_s);
         3'b111:  br_taken_s = (rs1_val_s >= rs2_val_s);
         default: br_taken_s = 1'b0;
      endcase
   end

   // Next-state sequencing; acks only matter in the state that raises the matching req
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_FETCH: if (insnAck) state_d = S_EXEC; else state_d = S_FETCH;
         S_EXEC:  if (is_load_s | is_store_s) state_d = S_MEM; else state_d = S_WB;
         S_MEM:   if (dataAck) state_d = S_WB; else state_d = S_MEM;
         S_WB:    state_d = S_FETCH;
         default: state_d = S_BOOT;
      endcase
   end

   // State, PC, IR and EXEC/MEM latches; reset abandons any in-flight access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         ir_q    <= 32'h0;
         alu_q   <= 32'h0;
         addr_q  <= 32'h0;
         sdata_q <= 32'h0;
         npc_q   <= 32'h0;
         ldata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_FETCH) && insnAck) begin
            ir_q <= insn;
         end
         if (state_q == S_EXEC) begin
            alu_q   <= alu_s;
            addr_q  <= rs1_val_s + (is_store_s ? imm_s_s : imm_i_s);
            sdata_q <= rs2_val_s;
            npc_q   <= (is_branch_s & br_taken_s) ? (pc_q + imm_b_s) : (pc_q + 32'd4);
         end
         if ((state_q == S_MEM) && dataAck && is_load_s) begin
            ldata_q <= dataIn;
         end
         if (state_q == S_WB) begin
            pc_q <= npc_q;
         end
      end
   end

   assign wb_data_s = is_load_s ? ldata_q : alu_q;

   // Register file write port, enabled only in WB
   always_ff @(posedge clk) begin
      if ((state_q == S_WB) && reg_wr_en_s && (rd_s != 5'd0)) begin
         rf_q[rd_s] <= wb_data_s;
      end
   end

   assign insnReq      = (state_q == S_FETCH);
   assign insnAddr     = (state_q == S_BOOT) ? 32'h0 : pc_q;
   assign dataReq      = (state_q == S_MEM);
   assign dataWrEnable = (state_q == S_MEM) & is_store_s;
   assign dataAddr     = addr_q;
   assign dataOut      = sdata_q;
   assign insnRetired  = (state_q == S_WB);

`ifdef CPU_PERF_COUNTERS_EN
   logic [COUNTER_WIDTH-1:0] cyc_q, ret_q;

   // Free-running cycle and retire counters, wrapping at full width
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (state_q != S_BOOT) begin
            cyc_q <= cyc_q + COUNTER_WIDTH'(1);
         end
         if (state_q == S_WB) begin
            ret_q <= ret_q + COUNTER_WIDTH'(1);
         end
      end
   end

   assign cycleCount  = cyc_q;
   assign retireCount = ret_q;
`else
   assign cycleCount  = '0;
   assign retireCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed testbench for multicycle_cpu: reset, ALU, stores, delayed load,
// branches, fetch wait states, reset during MEM, and performance counters.
module tb_multicycle_cpu;

   localparam int          CW  = 4;
   localparam logic [31:0] RPC = 32'h0000_0040;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   insnAddr, dataAddr, dataOut, insn, dataIn;
   logic          insnReq, insnAck, dataWrEnable, dataReq, dataAck, insnRetired;
   logic [CW-1:0] cycleCount, retireCount;

   int n_cmp  = 0;
   int n_fail = 0;

   multicycle_cpu #(.RESET_PC(RPC), .COUNTER_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .insnAddr(insnAddr), .insnReq(insnReq), .insnAck(insnAck), .insn(insn),
      .dataAddr(dataAddr), .dataOut(dataOut), .dataWrEnable(dataWrEnable),
      .dataReq(dataReq), .dataAck(dataAck), .dataIn(dataIn),
      .insnRetired(insnRetired), .cycleCount(cycleCount), .retireCount(retireCount)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction from FETCH to retirement, acting as both memories.
   task automatic run_insn(input logic [31:0] word, input int iwait, input int dwait,
                           input logic [31:0] ldata, input bit hold,
                           output int cycles, output int dreq_cycles,
                           output logic [31:0] daddr, output logic dwe,
                           output logic [31:0] dout, output bit stable);
      int iw = iwait;
      int dw = dwait;
      bit retired = 1'b0;
      bit seen_i = 1'b0;
      logic [31:0] faddr = 32'h0;
      cycles = 0; dreq_cycles = 0; daddr = 32'h0; dwe = 1'b0; dout = 32'h0; stable = 1'b1;
      while (!retired && cycles < 40) begin
         cycles++;
         insn = word;
         if (insnReq) begin
            if (seen_i && insnAddr !== faddr) stable = 1'b0;
            faddr = insnAddr; seen_i = 1'b1;
            insnAck = (iw == 0);
            if (iw > 0) iw--;
         end else begin
            insnAck = hold;
         end
         dataIn = ldata;
         if (dataReq) begin
            if (dreq_cycles == 0) begin
               daddr = dataAddr; dwe = dataWrEnable; dout = dataOut;
            end else if (dataAddr !== daddr || dataWrEnable !== dwe || dataOut !== dout) begin
               stable = 1'b0;
            end
            dreq_cycles++;
            dataAck = (dw == 0);
            if (dw > 0) dw--;
         end else begin
            dataAck = hold;
         end
         if (insnRetired) retired = 1'b1;
         tick();
      end
      insnAck = 1'b0;
      dataAck = 1'b0;
      if (!retired) cycles = -1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; insnAck = 1'b0; dataAck = 1'b0; insn = 32'h0; dataIn = 32'h0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      insnAck = 1'b0; dataAck = 1'b0; insn = 32'h0; dataIn = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({insnReq, dataReq, dataWrEnable, insnRetired} !== 4'b0000 || insnAddr !== 32'h0 ||
          dataAddr !== 32'h0 || dataOut !== 32'h0 || cycleCount !== 4'd0 || retireCount !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b dreq=%b ret=%b ia=%h da=%h cc=%0d rc=%0d, all must be 0",
                  insnReq, dataReq, insnRetired, insnAddr, dataAddr, cycleCount, retireCount);
      end
      rst = 1'b1;
      n_cmp++;
      if (insnReq !== 1'b0 || insnAddr !== 32'h0) begin
         n_fail++;
         $display("FAIL boot_cycle: insnReq=%b insnAddr=%h, required 0/0", insnReq, insnAddr);
      end
      tick();
      n_cmp++;
      if (insnReq !== 1'b1 || insnAddr !== RPC) begin
         n_fail++;
         $display("FAIL first_fetch: insnReq=%b insnAddr=%h, required 1/%h", insnReq, insnAddr, RPC);
      end
   endtask

   task automatic test_alu_store();
      int c, dc; logic [31:0] da, dd; logic we; bit st;
      run_insn(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 32'h0, 1'b1, c, dc, da, we, dd, st);
      n_cmp++;
      if (c !== 3 || insnAddr !== 32'h44) begin
         n_fail++;
         $display("FAIL addi_zero_wait: cycles=%0d next=%h, required 3/00000044", c, insnAddr);
      end
      run_insn(enc_i(12'h077, 5'd0, 3'b000, 5'd4, 7'b0010011), 2, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (c !== 5 || !st || insnAddr !== 32'h48) begin
         n_fail++;
         $display("FAIL fetch_wait: cycles=%0d stable=%0d next=%h, required 5/1/00000048", c, st, insnAddr);
      end
      run_insn(enc_s(12'd4, 5'd1, 5'd0), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (c !== 4 || dc !== 1 || we !== 1'b1 || dd !== 32'd5 || da !== 32'd4) begin
         n_fail++;
         $display("FAIL store_x1: cycles=%0d dreq=%0d we=%b dout=%h addr=%h, required 4/1/1/00000005/00000004",
                  c, dc, we, dd, da);
      end
      run_insn(enc_s(12'd0, 5'd4, 5'd0), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (dd !== 32'h77 || insnAddr !== 32'h50) begin
         n_fail++;
         $display("FAIL store_no_regwrite: x4=%h next=%h, required 00000077/00000050", dd, insnAddr);
      end
   endtask

   task automatic test_delayed_load();
      int c, dc; logic [31:0] da, dd; logic we; bit st;
      run_insn(enc_i(12'h100, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      run_insn(enc_i(12'd8, 5'd1, 3'b010, 5'd2, 7'b0000011), 0, 3, 32'hDEAD_BEEF, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (c !== 7 || dc !== 4 || da !== 32'h108 || we !== 1'b0 || !st) begin
         n_fail++;
         $display("FAIL load_wait3: cycles=%0d dreq=%0d addr=%h we=%b stable=%0d, required 7/4/00000108/0/1",
                  c, dc, da, we, st);
      end
      run_insn(enc_s(12'd0, 5'd2, 5'd0), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (dd !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL load_value: x2=%h, required deadbeef", dd);
      end
      run_insn({7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110011}, 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      run_insn(enc_s(12'd0, 5'd3, 5'd0), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (dd !== 32'hDEAD_BDEF || insnAddr !== 32'h64) begin
         n_fail++;
         $display("FAIL sub_reg: x3=%h next=%h, required deadbdef/00000064", dd, insnAddr);
      end
   endtask

   task automatic test_branches();
      int c, dc; logic [31:0] da, dd; logic we; bit st;
      run_insn(enc_b(13'h1FBC, 5'd0, 5'd0, 3'b000), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (insnAddr !== 32'h20 || c !== 3) begin
         n_fail++;
         $display("FAIL beq_backward: next=%h cycles=%0d, required 00000020/3", insnAddr, c);
      end
      run_insn(enc_b(13'd16, 5'd0, 5'd0, 3'b000), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (insnAddr !== 32'h30) begin
         n_fail++;
         $display("FAIL beq_taken: next=%h, required 00000030", insnAddr);
      end
      run_insn(enc_b(13'd16, 5'd0, 5'd0, 3'b001), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (insnAddr !== 32'h34) begin
         n_fail++;
         $display("FAIL bne_not_taken: next=%h, required 00000034", insnAddr);
      end
      run_insn(enc_b(13'd8, 5'd1, 5'd2, 3'b100), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (insnAddr !== 32'h3C) begin
         n_fail++;
         $display("FAIL blt_signed: next=%h, required 0000003c", insnAddr);
      end
      run_insn(enc_b(13'd8, 5'd1, 5'd2, 3'b110), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (insnAddr !== 32'h40) begin
         n_fail++;
         $display("FAIL bltu_not_taken: next=%h, required 00000040", insnAddr);
      end
   endtask

   task automatic test_reset_mid_mem();
      int c, dc; logic [31:0] da, dd; logic we; bit st;
      insn = enc_s(12'd0, 5'd1, 5'd0);
      insnAck = 1'b1;
      tick();
      insnAck = 1'b0;
      tick();
      n_cmp++;
      if (dataReq !== 1'b1 || dataWrEnable !== 1'b1) begin
         n_fail++;
         $display("FAIL mem_entry: dataReq=%b we=%b, required 1/1", dataReq, dataWrEnable);
      end
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({dataReq, dataWrEnable, insnReq, insnRetired} !== 4'b0000 || insnAddr !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset_mem: dreq=%b we=%b ireq=%b ret=%b ia=%h, required all 0",
                  dataReq, dataWrEnable, insnReq, insnRetired, insnAddr);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      n_cmp++;
      if (insnReq !== 1'b0) begin
         n_fail++;
         $display("FAIL reboot_boot: insnReq=%b, required 0", insnReq);
      end
      tick();
      n_cmp++;
      if (insnReq !== 1'b1 || insnAddr !== RPC) begin
         n_fail++;
         $display("FAIL reboot_fetch: insnReq=%b insnAddr=%h, required 1/%h", insnReq, insnAddr, RPC);
      end
      run_insn(enc_s(12'd0, 5'd1, 5'd0), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (dd !== 32'h100 || c !== 4) begin
         n_fail++;
         $display("FAIL after_reset_store: x1=%h cycles=%0d, required 00000100/4", dd, c);
      end
   endtask

   task automatic test_counters();
      int c, dc; logic [31:0] da, dd; logic we; bit st;
      logic [CW-1:0] exp_cc, exp_rc;
      apply_reset();
      tick();
      for (int k = 0; k < 6; k++) begin
         run_insn(enc_i(12'd1, 5'd5, 3'b000, 5'd5, 7'b0010011), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      end
`ifdef CPU_PERF_COUNTERS_EN
      exp_cc = 4'd2;
      exp_rc = 4'd6;
`else
      exp_cc = 4'd0;
      exp_rc = 4'd0;
`endif
      n_cmp++;
      if (cycleCount !== exp_cc || retireCount !== exp_rc) begin
         n_fail++;
         $display("FAIL counters: cycle=%0d retire=%0d, required %0d/%0d",
                  cycleCount, retireCount, exp_cc, exp_rc);
      end
      run_insn(enc_s(12'd0, 5'd5, 5'd0), 0, 0, 32'h0, 1'b0, c, dc, da, we, dd, st);
      n_cmp++;
      if (dd !== 32'd6) begin
         n_fail++;
         $display("FAIL addi_chain: x5=%h, required 00000006", dd);
      end
   endtask

   initial begin
      test_reset();
      test_alu_store();
      test_delayed_load();
      test_branches();
      test_reset_mid_mem();
      test_counters();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
